// File: rtl/register_file.sv
// Register file: 2**ADDR_W x WIDTH, two combinational read ports, one write port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read port.

module register_file_rd_port #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic                        rst_n,
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic [ADDR_W-1:0]           ra,
  input  logic                        byp_hit,
  input  logic [WIDTH-1:0]            byp_data,
  output logic [WIDTH-1:0]            rd
);

  // r0 and reset override everything, including forwarded data.
  always_comb begin
    rd = regs[ra];
    if (byp_hit)                 rd = byp_data;
    if (!rst_n || (ra == '0))    rd = '0;
  end

endmodule

module register_file #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2
);

  localparam int DEPTH  = 2**ADDR_W;
  localparam int NUM_RD = 2;

  logic [DEPTH-1:0][WIDTH-1:0]  regs_q, regs_d;
  logic [NUM_RD-1:0][ADDR_W-1:0] ra;
  logic [NUM_RD-1:0][WIDTH-1:0]  rd;
  logic [NUM_RD-1:0]             byp_hit;
  logic                          wr_en;

  assign ra    = {ra2, ra1};
  assign rd1   = rd[0];
  assign rd2   = rd[1];
  assign wr_en = we && (wa != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wa] = wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
    assign byp_hit[p] = wr_en && (ra[p] == wa);
`else
    assign byp_hit[p] = 1'b0;
`endif

    register_file_rd_port #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
    ) u_rd (
      .rst_n    (rst_n),
      .regs     (regs_q),
      .ra       (ra[p]),
      .byp_hit  (byp_hit[p]),
      .byp_data (wd),
      .rd       (rd[p])
    );
  end

endmodule
